// File: rtl/dmem_lsu_pkg.sv
// Shared encodings for the data-memory load/store unit.
// Size codes, FSM states and the big-endian lane-shift helper.
package dmem_lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;
  localparam logic [1:0] SZ_ILL  = 2'd3;

  localparam logic [31:0] BYTE_MASK = 32'h0000_00FF;
  localparam logic [31:0] HALF_MASK = 32'h0000_FFFF;
  localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RD_WAIT,
    ST_WRITE,
    ST_RESP
  } state_t;

  // Big-endian: offset 0 is the most significant lane, so the shift shrinks as offset grows.
  function automatic logic [4:0] lane_shift(input logic [1:0] size, input logic [1:0] offset);
    case (size)
      SZ_BYTE: return 5'd24 - {offset, 3'b000};
      SZ_HALF: return offset[1] ? 5'd0 : 5'd16;
      default: return 5'd0;
    endcase
  endfunction

endpackage

// File: rtl/dmem_lsu_if.sv
// Request/response handshake between the MEM stage (master) and the load/store unit (slave).
interface dmem_lsu_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_error;

  modport master (
    output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_error
  );

  modport slave (
    input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_error
  );
endinterface

// File: rtl/dmem_lsu_lane.sv
// Big-endian byte-lane datapath: merges store data into a memory word and
// extracts/extends a load lane from a memory word.
module dmem_lsu_lane
  import dmem_lsu_pkg::*;
(
  input  logic [1:0]  i_size,
  input  logic [1:0]  i_offset,
  input  logic        i_signed,
  input  logic [31:0] i_word,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_merged,
  output logic [31:0] o_load
);

  logic [4:0]  w_shift;
  logic [31:0] w_mask;
  logic [31:0] w_raw;

  always_comb begin
    w_shift = lane_shift(i_size, i_offset);
    case (i_size)
      SZ_BYTE: w_mask = BYTE_MASK;
      SZ_HALF: w_mask = HALF_MASK;
      default: w_mask = WORD_MASK;
    endcase

    // Word accesses have a full mask and zero shift, so the merge degenerates to i_wdata.
    o_merged = (i_word & ~(w_mask << w_shift)) | ((i_wdata & w_mask) << w_shift);

    w_raw  = (i_word >> w_shift) & w_mask;
    o_load = w_raw;
    if (i_signed && (i_size == SZ_BYTE) && w_raw[7]) begin
      o_load = w_raw | 32'hFFFF_FF00;
    end else if (i_signed && (i_size == SZ_HALF) && w_raw[15]) begin
      o_load = w_raw | 32'hFFFF_0000;
    end
  end

endmodule

// File: rtl/dmem_lsu.sv
// Load/store initiator for the word-wide, big-endian data memory; sub-word stores
// are performed as read-modify-write.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// ST_IDLE    | ready for a request; all memory strobes low
// ST_RD_WAIT | mem_read held RD_LAT cycles; word captured on the last one
// ST_WRITE   | single-cycle mem_write of the final (possibly merged) word
// ST_RESP    | one-cycle resp_valid with extended data or error
module dmem_lsu
  import dmem_lsu_pkg::*;
#(
  parameter int MEM_BYTES = 256,
  parameter int RD_LAT    = 1
) (
  input  logic        i_clk,
  input  logic        i_reset,
  dmem_lsu_if.slave   bus,
  input  logic [31:0] i_mem_rdata,
  output logic [31:0] o_mem_address,
  output logic [31:0] o_mem_wdata,
  output logic        o_mem_write,
  output logic        o_mem_read
);

  localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(RD_LAT - 1);

  state_t            r_state, w_next;
  logic              r_write, r_signed, r_err;
  logic [1:0]        r_size;
  logic [31:0]       r_addr, r_wdata, r_word;
  logic [CNT_W-1:0]  r_cnt;

  logic [31:0] w_base, w_merged, w_load;
  logic        w_err;

  assign w_base = {bus.req_addr[31:2], 2'b00};
  assign w_err  = (bus.req_size == SZ_ILL)
               || ((bus.req_size == SZ_HALF) && bus.req_addr[0])
               || ((bus.req_size == SZ_WORD) && (bus.req_addr[1:0] != 2'b00))
               || (w_base > 32'(MEM_BYTES - 4));

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state  <= ST_IDLE;
      r_write  <= 1'b0;
      r_signed <= 1'b0;
      r_err    <= 1'b0;
      r_size   <= SZ_BYTE;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_word   <= '0;
      r_cnt    <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        ST_IDLE: begin
          if (bus.req_valid) begin
            r_write  <= bus.req_write;
            r_signed <= bus.req_signed;
            r_size   <= bus.req_size;
            r_addr   <= bus.req_addr;
            r_wdata  <= bus.req_wdata;
            r_err    <= w_err;
            r_cnt    <= CNT_INIT;
          end
        end
        ST_RD_WAIT: begin
          if (r_cnt == '0) r_word <= i_mem_rdata;
          else             r_cnt  <= r_cnt - 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (bus.req_valid) begin
          if (w_err)                                         w_next = ST_RESP;
          else if (bus.req_write && bus.req_size == SZ_WORD) w_next = ST_WRITE;
          else                                               w_next = ST_RD_WAIT;
        end
      end
      ST_RD_WAIT: if (r_cnt == '0) w_next = r_write ? ST_WRITE : ST_RESP;
      ST_WRITE:   w_next = ST_RESP;
      ST_RESP:    w_next = ST_IDLE;
      default:    w_next = ST_IDLE;
    endcase
  end

  dmem_lsu_lane u_lane (
    .i_size   (r_size),
    .i_offset (r_addr[1:0]),
    .i_signed (r_signed),
    .i_word   (r_word),
    .i_wdata  (r_wdata),
    .o_merged (w_merged),
    .o_load   (w_load)
  );

  // Outputs decode purely from state so reset forces every strobe low in the same cycle.
  assign bus.req_ready  = (r_state == ST_IDLE);
  assign bus.resp_valid = (r_state == ST_RESP);
  assign bus.resp_error = (r_state == ST_RESP) && r_err;
  assign bus.resp_rdata = ((r_state == ST_RESP) && !r_err && !r_write) ? w_load : 32'h0;

  assign o_mem_read    = (r_state == ST_RD_WAIT);
  assign o_mem_write   = (r_state == ST_WRITE);
  assign o_mem_address = (o_mem_read || o_mem_write) ? {r_addr[31:2], 2'b00} : 32'h0;
  assign o_mem_wdata   = o_mem_write ? w_merged : 32'h0;

endmodule

// File: tb/tb_dmem_lsu.sv
// Directed bench for dmem_lsu with a behavioural word memory honouring RD_LAT.
module tb_dmem_lsu;
  import dmem_lsu_pkg::*;

  localparam int MEM_BYTES = 256;
  localparam int RD_LAT    = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] mem_address, mem_wdata, mem_rdata;
  logic        mem_write, mem_read;

  dmem_lsu_if bus();

  dmem_lsu #(.MEM_BYTES(MEM_BYTES), .RD_LAT(RD_LAT)) dut (
    .i_clk         (clk),
    .i_reset       (rst),
    .bus           (bus),
    .i_mem_rdata   (mem_rdata),
    .o_mem_address (mem_address),
    .o_mem_wdata   (mem_wdata),
    .o_mem_write   (mem_write),
    .o_mem_read    (mem_read)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:63];
  int          rd_run = 0;
  int          wr_total = 0, rd_total = 0, ovl_total = 0;
  logic [31:0] last_wdata = 32'h0;

  // Data is garbage until the read has been held RD_LAT cycles.
  assign mem_rdata = (mem_read && rd_run >= RD_LAT - 1) ? mem[mem_address[7:2]] : 32'hBAD0_BAD0;

  always @(posedge clk) rd_run <= mem_read ? rd_run + 1 : 0;

  always @(negedge clk) begin
    if (mem_write) begin
      wr_total                <= wr_total + 1;
      last_wdata              <= mem_wdata;
      mem[mem_address[7:2]]   <= mem_wdata;
    end
    if (mem_read)              rd_total  <= rd_total + 1;
    if (mem_read && mem_write) ovl_total <= ovl_total + 1;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, " ready"},  32'(bus.req_ready),  32'd1);
    check({tag, " rvalid"}, 32'(bus.resp_valid), 32'd0);
    check({tag, " rerr"},   32'(bus.resp_error), 32'd0);
    check({tag, " rdata"},  bus.resp_rdata,      32'd0);
    check({tag, " mrd"},    32'(mem_read),       32'd0);
    check({tag, " mwr"},    32'(mem_write),      32'd0);
    check({tag, " maddr"},  mem_address,         32'd0);
    check({tag, " mwdata"}, mem_wdata,           32'd0);
  endtask

  task automatic wait_ready();
    int guard = 0;
    @(negedge clk);
    while (!bus.req_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
  endtask

  task automatic do_req(input string tag, input logic w, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] wd, input int exp_lat,
                        input logic exp_err, input logic [31:0] exp_rd, input int exp_wr,
                        input int exp_rdc, input logic [31:0] exp_wd);
    int lat, wr0, rd0;
    logic got_err;
    logic [31:0] got_rd;
    wait_ready();
    wr0 = wr_total;
    rd0 = rd_total;
    bus.req_write  = w;
    bus.req_size   = sz;
    bus.req_signed = sg;
    bus.req_addr   = a;
    bus.req_wdata  = wd;
    bus.req_valid  = 1'b1;
    @(posedge clk); #1;
    // Scramble the request after acceptance; the DUT must use its latched copy.
    bus.req_valid  = 1'b0;
    bus.req_addr   = ~a;
    bus.req_wdata  = ~wd;
    bus.req_size   = sz ^ 2'b01;
    bus.req_signed = ~sg;
    bus.req_write  = ~w;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus.resp_valid && lat < 20);
    got_err = bus.resp_error;
    got_rd  = bus.resp_rdata;
    @(posedge clk); #1;
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check({tag, " error"},   32'(got_err), 32'(exp_err));
    check({tag, " rdata"},   got_rd, exp_rd);
    check({tag, " writes"},  32'(wr_total - wr0), 32'(exp_wr));
    check({tag, " reads"},   32'(rd_total - rd0), 32'(exp_rdc));
    if (exp_wr != 0) check({tag, " wdata"}, last_wdata, exp_wd);
  endtask

  initial begin
    logic [15:0] rdy_vec;
    logic [31:0] addr_c2, addr_c7, rdata_c4, rdata_c9;
    int wr0;

    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_size = SZ_WORD;
    bus.req_signed = 1'b0; bus.req_addr = 32'h0; bus.req_wdata = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("reset");
    rst = 1'b0;

    // w, size, signed, addr, wdata, lat, err, rdata, writes, reads, wdata
    do_req("sw10",  1, SZ_WORD, 0, 32'h10, 32'hDEADBEEF, 2, 0, 32'h0, 1, 0, 32'hDEADBEEF);
    do_req("lw10",  0, SZ_WORD, 0, 32'h10, 32'h0, RD_LAT+1, 0, 32'hDEADBEEF, 0, RD_LAT, 32'h0);
    do_req("sw20",  1, SZ_WORD, 0, 32'h20, 32'h11223344, 2, 0, 32'h0, 1, 0, 32'h11223344);
    do_req("sb21",  1, SZ_BYTE, 0, 32'h21, 32'h123456AA, RD_LAT+2, 0, 32'h0, 1, RD_LAT, 32'h11AA3344);
    do_req("sh22",  1, SZ_HALF, 0, 32'h22, 32'hCAFEBEEF, RD_LAT+2, 0, 32'h0, 1, RD_LAT, 32'h11AABEEF);
    do_req("lw20",  0, SZ_WORD, 0, 32'h20, 32'h0, RD_LAT+1, 0, 32'h11AABEEF, 0, RD_LAT, 32'h0);
    do_req("sw30",  1, SZ_WORD, 0, 32'h30, 32'h80FF7F01, 2, 0, 32'h0, 1, 0, 32'h80FF7F01);
    do_req("lb30",  0, SZ_BYTE, 1, 32'h30, 32'h0, RD_LAT+1, 0, 32'hFFFFFF80, 0, RD_LAT, 32'h0);
    do_req("lbu30", 0, SZ_BYTE, 0, 32'h30, 32'h0, RD_LAT+1, 0, 32'h00000080, 0, RD_LAT, 32'h0);
    do_req("lh30",  0, SZ_HALF, 1, 32'h30, 32'h0, RD_LAT+1, 0, 32'hFFFF80FF, 0, RD_LAT, 32'h0);
    do_req("lhu32", 0, SZ_HALF, 0, 32'h32, 32'h0, RD_LAT+1, 0, 32'h00007F01, 0, RD_LAT, 32'h0);
    do_req("lh32",  0, SZ_HALF, 1, 32'h32, 32'h0, RD_LAT+1, 0, 32'h00007F01, 0, RD_LAT, 32'h0);
    do_req("lb31",  0, SZ_BYTE, 1, 32'h31, 32'h0, RD_LAT+1, 0, 32'hFFFFFFFF, 0, RD_LAT, 32'h0);
    do_req("lb33",  0, SZ_BYTE, 1, 32'h33, 32'h0, RD_LAT+1, 0, 32'h00000001, 0, RD_LAT, 32'h0);
    do_req("lws30", 0, SZ_WORD, 1, 32'h30, 32'h0, RD_LAT+1, 0, 32'h80FF7F01, 0, RD_LAT, 32'h0);

    do_req("err_lw31",  0, SZ_WORD, 0, 32'h31,  32'h0, 1, 1, 32'h0, 0, 0, 32'h0);
    do_req("err_sh23",  1, SZ_HALF, 0, 32'h23,  32'hFFFF, 1, 1, 32'h0, 0, 0, 32'h0);
    do_req("err_sz3",   0, SZ_ILL,  0, 32'h40,  32'h0, 1, 1, 32'h0, 0, 0, 32'h0);
    do_req("err_lwFD",  0, SZ_WORD, 0, 32'hFD,  32'h0, 1, 1, 32'h0, 0, 0, 32'h0);
    do_req("err_sw100", 1, SZ_WORD, 0, 32'h100, 32'h1, 1, 1, 32'h0, 0, 0, 32'h0);
    do_req("swFC",  1, SZ_WORD, 0, 32'hFC, 32'h12345678, 2, 0, 32'h0, 1, 0, 32'h12345678);
    do_req("lwFC",  0, SZ_WORD, 0, 32'hFC, 32'h0, RD_LAT+1, 0, 32'h12345678, 0, RD_LAT, 32'h0);

    // Reset while a sub-word store is still reading.
    wait_ready();
    wr0 = wr_total;
    bus.req_write = 1'b1; bus.req_size = SZ_BYTE; bus.req_signed = 1'b0;
    bus.req_addr = 32'h21; bus.req_wdata = 32'h55; bus.req_valid = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(negedge clk);
    check("rst_mid in_read", 32'(mem_read), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    check_idle_outputs("rst_mid");
    rst = 1'b0;
    repeat (RD_LAT + 2) @(posedge clk);
    #1;
    check("rst_mid writes", 32'(wr_total - wr0), 32'd0);
    do_req("lw20_after_rst", 0, SZ_WORD, 0, 32'h20, 32'h0, RD_LAT+1, 0, 32'h11AABEEF, 0, RD_LAT, 32'h0);

    // Back-to-back loads with req_valid held high.
    wait_ready();
    bus.req_write = 1'b0; bus.req_size = SZ_WORD; bus.req_signed = 1'b0;
    bus.req_addr = 32'h10; bus.req_valid = 1'b1;
    rdy_vec = '0; addr_c2 = '0; addr_c7 = '0; rdata_c4 = '0; rdata_c9 = '0;
    for (int c = 0; c < 16; c++) begin
      rdy_vec[c] = bus.req_ready;
      if (c == 2) addr_c2 = mem_address;
      if (c == 7) addr_c7 = mem_address;
      if (c == 4 && bus.resp_valid) rdata_c4 = bus.resp_rdata;
      if (c == 9 && bus.resp_valid) rdata_c9 = bus.resp_rdata;
      @(posedge clk); #1;
      if (c == 0) bus.req_addr = 32'h30;
      @(negedge clk);
    end
    bus.req_valid = 1'b0;
    check("b2b ready_pattern", 32'(rdy_vec), 32'h0000_8421);
    check("b2b addr_held",     addr_c2, 32'h10);
    check("b2b addr_second",   addr_c7, 32'h30);
    check("b2b rdata_first",   rdata_c4, 32'hDEADBEEF);
    check("b2b rdata_second",  rdata_c9, 32'h80FF7F01);
    wait_ready();

    check("strobe_overlap", 32'(ovl_total), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
